accel_cmd_seq: RTL

Command sequencer for the configurable accelerator's 4-bit-address / 8-bit-data register port. A host (TinyQV-side glue or PMOD logic) queues register writes, reads, fixed waits and bit-polls into a small FIFO, then pulses `start`. The block replays the queue against the accelerator port without host involvement and reports read data, completion and a poll-timeout error.

---
 rtl/accel_cmd_seq.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/accel_cmd_seq.sv
// Command sequencer: replays a queue of WRITE/READ/WAIT/POLL commands against the
// accelerator's 4-bit-address / 8-bit-data register port, reporting read data and completion.
module accel_cmd_seq #(
  parameter int DEPTH        = 4,
  parameter int POLL_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_addr,
  input  logic [7:0] cmd_data,
  input  logic       start,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic [3:0] acc_address,
  output logic       acc_data_write,
  output logic [7:0] acc_data_in,
  input  logic [7:0] acc_data_out
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [7:0] POLL_LAST = 8'(POLL_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DISPATCH,
    S_WR,
    S_RD,
    S_WAIT,
    S_POLL
  } state_t;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_WAIT  = 2'b10,
    OP_POLL  = 2'b11
  } op_t;

  state_t      state;
  logic [13:0] mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        full;
  logic        empty;
  logic        push;
  logic [13:0] head;
  op_t         head_op;
  logic [7:0]  mask;
  logic [7:0]  wait_cnt;
  logic [7:0]  poll_cnt;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty     = (wr_ptr == rd_ptr);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full && !abort;
  assign head      = mem[rd_ptr[AW-1:0]];
  assign head_op   = op_t'(head[13:12]);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {cmd_op, cmd_addr, cmd_data};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      rd_data        <= '0;
      rd_valid       <= 1'b0;
      acc_address    <= '0;
      acc_data_write <= 1'b0;
      acc_data_in    <= '0;
      mask           <= '0;
      wait_cnt       <= '0;
      poll_cnt       <= '0;
    end else begin
      done           <= 1'b0;
      rd_valid       <= 1'b0;
      acc_data_write <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;

      // Flush assignments below override the push increment above.
      if (abort) begin
        state  <= S_IDLE;
        busy   <= 1'b0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state <= S_DISPATCH;
              busy  <= 1'b1;
              error <= 1'b0;
            end
          end
          S_DISPATCH: begin
            if (empty) begin
              state <= S_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              rd_ptr      <= rd_ptr + 1'b1;
              acc_address <= head[11:8];
              case (head_op)
                OP_WRITE: begin
                  acc_data_in    <= head[7:0];
                  acc_data_write <= 1'b1;
                  state          <= S_WR;
                end
                OP_READ: state <= S_RD;
                OP_WAIT: begin
                  wait_cnt <= head[7:0];
                  state    <= S_WAIT;
                end
                default: begin
                  mask     <= head[7:0];
                  poll_cnt <= '0;
                  state    <= S_POLL;
                end
              endcase
            end
          end
          S_WR: state <= S_DISPATCH;
          S_RD: begin
            rd_data  <= acc_data_out;
            rd_valid <= 1'b1;
            state    <= S_DISPATCH;
          end
          S_WAIT: begin
            if (wait_cnt == '0) state <= S_DISPATCH;
            else wait_cnt <= wait_cnt - 1'b1;
          end
          S_POLL: begin
            if ((acc_data_out & mask) != '0) begin
              state <= S_DISPATCH;
            end else if (poll_cnt == POLL_LAST) begin
              // Timeout abandons the rest of the queue but still reports completion.
              state  <= S_IDLE;
              busy   <= 1'b0;
              done   <= 1'b1;
              error  <= 1'b1;
              wr_ptr <= '0;
              rd_ptr <= '0;
            end else begin
              poll_cnt <= poll_cnt + 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
